// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with load forwarding; STB_COALESCE_EN merges repeat stores
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_write,
    input  logic [AW-1:0]            data_adr,
    input  logic [DW-1:0]            write_data,
    output logic                     stall,
    output logic                     ld_hit,
    output logic [DW-1:0]            ld_data,
    output logic                     mem_valid,
    output logic [AW-1:0]            mem_adr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    adr_mem  [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    youngest;
    logic             full;
    logic             coalesce;
    logic             enq;
    logic             deq;

    wire unused_adr_lsbs = &{1'b0, data_adr[1:0]};

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign mem_valid = ~empty;
    assign youngest  = wr_ptr - PW'(1);

`ifdef STB_COALESCE_EN
    // Youngest entry must not be the head, otherwise it could be draining right now.
    assign coalesce = mem_write && (count >= CW'(2)) && vld[youngest] &&
                      (adr_mem[youngest][AW-1:2] == data_adr[AW-1:2]);
`else
    assign coalesce = 1'b0;
`endif

    assign stall = mem_write & full & ~coalesce;
    assign enq   = mem_write & ~full & ~coalesce;
    assign deq   = mem_valid & mem_ready;

    // Output zero while empty so stale storage never reaches memory.
    assign mem_adr   = empty ? '0 : adr_mem[rd_ptr];
    assign mem_wdata = empty ? '0 : data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (enq) begin
            adr_mem[wr_ptr]  <= data_adr;
            data_mem[wr_ptr] <= write_data;
        end
        if (coalesce) begin
            data_mem[youngest] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (deq) begin
                rd_ptr      <= rd_ptr + PW'(1);
                vld[rd_ptr] <= 1'b0;
            end
            if (enq) begin
                wr_ptr      <= wr_ptr + PW'(1);
                vld[wr_ptr] <= 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Walk from youngest to oldest; first word match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = wr_ptr - PW'(1) - PW'(i);
            if (!ld_hit && (CW'(i) < count) && vld[idx] &&
                (adr_mem[idx][AW-1:2] == data_adr[AW-1:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_mem[idx];
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer with queue reference model
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_write = 1'b0;
    logic [AW-1:0] data_adr = '0;
    logic [DW-1:0] write_data = '0;
    logic          stall;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          mem_valid;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [2:0]    count;
    logic          empty;

    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data), .stall(stall), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_valid(mem_valid), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Handshakes are sampled mid-cycle; the queue front is the entry memory must receive.
    always @(negedge clk) begin
        if (!reset && mem_valid && mem_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL drain_unexpected: got adr %0h data %0h expected no handshake", mem_adr, mem_wdata);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("drain_adr", 64'(mem_adr), 64'(e.adr));
                chk("drain_data", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    task automatic cycle(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic r);
        bit            is_full, co, hit;
        logic [DW-1:0] fdata;
        @(posedge clk);
        #1;
        mem_write  = w;
        data_adr   = a;
        write_data = d;
        mem_ready  = r;
        #1;
        is_full = (exp_q.size() == DEPTH);
        co = 1'b0;
`ifdef STB_COALESCE_EN
        if (w && exp_q.size() >= 2 && exp_q[$].adr[AW-1:2] == a[AW-1:2]) co = 1'b1;
`endif
        chk("stall", 64'(stall), 64'(w && is_full && !co));
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("empty", 64'(empty), 64'(exp_q.size() == 0));
        chk("mem_valid", 64'(mem_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("head_adr", 64'(mem_adr), 64'(exp_q[0].adr));
            chk("head_data", 64'(mem_wdata), 64'(exp_q[0].data));
        end
        hit   = 1'b0;
        fdata = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].adr[AW-1:2] == a[AW-1:2]) begin
                hit   = 1'b1;
                fdata = exp_q[i].data;
                break;
            end
        end
        chk("ld_hit", 64'(ld_hit), 64'(hit));
        chk("ld_data", 64'(ld_data), 64'(fdata));
        if (co) exp_q[exp_q.size() - 1].data = d;
        else if (w && !is_full) exp_q.push_back('{a, d});
    endtask

    task automatic drain_all();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            cycle(1'b0, '0, '0, 1'b1);
            budget++;
        end
        @(negedge clk);
        #1;
        chk("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_valid", 64'(mem_valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        reset = 1'b0;
        repeat (2) cycle(1'b0, '0, '0, 1'b0);

        cycle(1'b1, 32'd96, 32'd7, 1'b0);
        cycle(1'b1, 32'd100, 32'd25, 1'b0);
        repeat (3) cycle(1'b0, 32'd8, '0, 1'b0);
        repeat (2) cycle(1'b0, 32'd8, '0, 1'b1);
        cycle(1'b0, 32'd8, '0, 1'b0);
        chk("pair_empty", 64'(empty), 64'd1);

        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(8 + 16 * i), 32'(50 + i), 1'b0);
        cycle(1'b1, 32'd104, 32'd99, 1'b0);
        chk("full_stall", 64'(stall), 64'd1);
        cycle(1'b1, 32'd104, 32'd99, 1'b1);
        chk("full_stall_deq", 64'(stall), 64'd1);
        cycle(1'b1, 32'd104, 32'd99, 1'b0);
        chk("refill_accept", 64'(stall), 64'd0);
        cycle(1'b0, 32'd104, '0, 1'b0);
        chk("refill_count", 64'(count), 64'd4);
        drain_all();

        cycle(1'b1, 32'd100, 32'd25, 1'b0);
        cycle(1'b1, 32'd100, 32'd30, 1'b0);
        cycle(1'b0, 32'd102, '0, 1'b0);
        chk("fwd_young_data", 64'(ld_data), 64'd30);
        cycle(1'b0, 32'd108, '0, 1'b0);
        chk("fwd_miss_hit", 64'(ld_hit), 64'd0);
        drain_all();

        for (int i = 0; i < 20; i++) cycle(1'b1, 32'(4 * i), 32'(200 + i), (i % 2) == 0);
        drain_all();

        cycle(1'b1, 32'd96, 32'd1, 1'b0);
        cycle(1'b1, 32'd100, 32'd2, 1'b0);
        cycle(1'b1, 32'd100, 32'd3, 1'b0);
        cycle(1'b0, 32'd0, '0, 1'b0);
`ifdef STB_COALESCE_EN
        chk("coalesce_count", 64'(count), 64'd2);
`else
        chk("nocoalesce_count", 64'(count), 64'd3);
`endif
        drain_all();

        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            a = {25'd0, 3'($urandom_range(0, 7)), 2'b00, 2'($urandom)};
            cycle(1'($urandom_range(0, 2) != 0), a, $urandom, 1'($urandom_range(0, 2) == 0));
        end
        drain_all();

        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(64 + 4 * i), 32'(i + 1), 1'b0);
        cycle(1'b0, '0, '0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_valid", 64'(mem_valid), 64'd0);
        chk("midrst_empty", 64'(empty), 64'd1);
        chk("midrst_head", 64'(mem_adr), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) cycle(1'b0, 32'd64, '0, 1'b1);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
